rapcores_wb_spi_bridge: RTL
===========================

# rapcores_wb_spi_bridge

Wishbone-slave command bridge upstream of the `rapcore` motor controller. The management SoC writes 32-bit command words over the user-area Wishbone port. The block queues them in a TX FIFO and serialises each one as an SPI mode-0 master frame onto the `SCK`/`CS`/`COPI` inputs of `rapcore`. With receive capture compiled in, it also returns `rapcore`'s `CIPO` reply words.

## Interface
- `FIFO_DEPTH`, default 8: entries per FIFO; power of two, ≥2.
- `CLK_DIV`, default 4: `wb_clk_i` cycles per SCK half-period; ≥2.
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle, write-enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  address; only [3:2] decoded, base decode is external.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  transfer acknowledge.
- `wbs_dat_o`  out  32  read data.
- `spi_sck_o`, `spi_cs_o`, `spi_copi_o`  out  1 each  to `rapcore` `SCK`, `CS` (active-low), `COPI`.
- `spi_cipo_i`  in  1  from `rapcore` `CIPO`.
- `busy_o`  out  1  high while a frame is in flight or the TX FIFO is non-empty.

## Operation
- Registers are selected by `adr[3:2]`:
  - 0 = TXDATA (W): push.
  - 1 = RXDATA (R): pop.
  - 2 = STATUS (R): [7:4] tx_count, [11:8] rx_count, [12] busy, [13] tx_ovf, [14] rx_ovf, rest 0.
  - 3 = CTRL (R/W): [0] enable, reset 0; write [1]=1 clears both ovf bits, self-clearing, reads 0.
- TXDATA writes push only when `sel==4'hF`; other `sel` values are acked and ignored.
- Push while full (count sampled before this cycle; a same-cycle SPI pop does not free space): word dropped, tx_ovf set.
- RXDATA read while empty: returns 0, no pop, no flag.
- Unmapped bits and write-to-read-only are ignored and acked.
- SPI FSM states: IDLE → SETUP → SHIFT_H/SHIFT_L ×32 → HOLD → GAP → IDLE.
  - IDLE→SETUP: when enable=1 and TX non-empty. Pop the word into the shifter; `cs`=0; `copi`=bit31.
  - SETUP: lasts CLK_DIV cycles.
  - SHIFT_H: `sck`=1; sample `cipo` into the receive shifter on entry.
  - SHIFT_L: `sck`=0; present the next bit (MSB first) on entry.
  - HOLD: `cs` stays 0 for CLK_DIV cycles after the last falling edge. Then `cs`=1 and the completed RX word is pushed; if RX is full, the word is dropped and rx_ovf set.
  - GAP: `cs`=1 for CLK_DIV cycles, then IDLE.
- enable cleared mid-frame: the current frame completes; no new frame starts.
- `wb_rst_i` asserted at any time: FSM→IDLE, FIFOs emptied, flags and CTRL cleared, `cs` high immediately. A truncated frame is not resumed.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `spi_sck_o`=0, `spi_cs_o`=1, `spi_copi_o`=0.
  - `busy_o`=0.
- Wishbone ack: `ack` rises one cycle after `cyc&&stb` is first seen and lasts exactly one cycle. `ack` is never high two consecutive cycles. The side effect (push/pop/flag) occurs in the ack cycle. `dat_o` is valid in the ack cycle and 0 otherwise.
- Frame length: CLK_DIV×(1+64+1) cycles from `cs` fall to `cs` rise, plus CLK_DIV cycles of GAP.
- First `cs` fall occurs 1 cycle after the push becomes visible in the FIFO, when idle and enabled.
- STATUS busy and `busy_o` are identical and registered.

## Configuration
- `RAPCORES_SPI_RX_EN` defined: CIPO is sampled and the RX FIFO is present, as above.
- `RAPCORES_SPI_RX_EN` not defined: no RX FIFO or receive shifter; `spi_cipo_i` is unused; RXDATA reads 0; rx_count and rx_ovf read 0. TX behaviour and frame timing are unchanged.

## Structure
- Shared package `rapcores_spi_pkg` holds:
  - register offset constants (TXDATA, RXDATA, STATUS, CTRL);
  - STATUS/CTRL bit-position constants;
  - the SPI FSM state typedef.
- Sub-module `rapcores_sync_fifo` (parameterised width/depth, count output, same-cycle push+pop legal) is instantiated once for TX and once for RX when `RAPCORES_SPI_RX_EN` is defined.

## Test plan
- Reset: assert `wb_rst_i` mid-frame (after bit 10) → `cs`=1 and `sck`=0 the same cycle; STATUS reads 0x0 after release.
- Single frame, CLK_DIV=4:
  - Stimulus: CTRL=1, write TXDATA=0xA5C3_0F01.
  - Expect exactly 32 SCK rising edges; COPI matches 0xA5C3_0F01 MSB-first at each rising edge.
  - Expect `cs` low for 264 cycles.
- RX loopback (`RAPCORES_SPI_RX_EN`): tie `cipo` to `copi`, send 0x1234_5678 → RXDATA reads 0x1234_5678, then rx_count=0.
- Overflow: enable=0, write 9 words → tx_count=8, tx_ovf=1. Write CTRL=0x2 → tx_ovf=0. Set enable=1 → 8 frames are sent, in order.
- Wishbone protocol: hold `stb` for 5 cycles on a STATUS read → exactly one `ack` pulse, at cycle 1; a TXDATA write with `sel`=4'h3 → acked, tx_count unchanged.
- Enable drop: clear enable during frame 1 of 3 queued → frame 1 completes; `cs` stays high; tx_count=2.

Source files
------------

// File: rtl/rapcores_spi_pkg.sv
// Shared constants and FSM state encoding for the rapcore Wishbone-to-SPI command bridge.
package rapcores_spi_pkg;

  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegRxData = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  localparam int unsigned StatTxCntLsb  = 4;
  localparam int unsigned StatRxCntLsb  = 8;
  localparam int unsigned StatBusyBit   = 12;
  localparam int unsigned StatTxOvfBit  = 13;
  localparam int unsigned StatRxOvfBit  = 14;
  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlClrOvfBit = 1;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t StIdle   = 3'd0;
  localparam spi_state_t StSetup  = 3'd1;
  localparam spi_state_t StShiftH = 3'd2;
  localparam spi_state_t StShiftL = 3'd3;
  localparam spi_state_t StHold   = 3'd4;
  localparam spi_state_t StGap    = 3'd5;

endpackage

// File: rtl/rapcores_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may occur in the same cycle.
module rapcores_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rapcores_wb_spi_bridge.sv
// Wishbone slave that queues 32-bit command words and ships them to rapcore as SPI mode-0 frames.
// Define RAPCORES_SPI_RX_EN to build the CIPO receive shifter and RX FIFO.
module rapcores_wb_spi_bridge
  import rapcores_spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        spi_sck_o,
  output logic        spi_cs_o,
  output logic        spi_copi_o,
  input  logic        spi_cipo_i,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic             req, ack_q, ack_d, done_q, done_d, wr_cyc, rd_cyc;
  logic [1:0]       reg_sel;
  logic             tx_wr, tx_push, tx_pop, tx_full, tx_empty, ctrl_wr, clr_ovf;
  logic [31:0]      tx_head, rdata;
  logic [CntW-1:0]  tx_count;
  logic             en_q, en_d, tx_ovf_q, tx_ovf_d, busy_q, busy_d;
  spi_state_t       state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic             cs_q, cs_d, sck_q, sck_d, phase_done, sck_rise, frame_end;
  logic [31:0]      tx_sh_q, tx_sh_d;
  logic [3:0]       rx_cnt4;
  logic [31:0]      rx_word;
  logic             rx_ovf;
  logic             unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

  // Ack once per strobe: done_q blocks re-acking until the master drops the request.
  assign req     = wbs_cyc_i & wbs_stb_i;
  assign ack_d   = req & ~ack_q & ~done_q;
  assign done_d  = req & (ack_q | done_q);
  assign wr_cyc  = ack_q & wbs_we_i;
  assign rd_cyc  = ack_q & ~wbs_we_i;
  assign reg_sel = wbs_adr_i[3:2];

  assign tx_wr   = wr_cyc & (reg_sel == RegTxData) & (wbs_sel_i == 4'hF);
  assign tx_push = tx_wr & ~tx_full;
  assign ctrl_wr = wr_cyc & (reg_sel == RegCtrl);
  assign clr_ovf = ctrl_wr & wbs_dat_i[CtrlClrOvfBit];

  assign en_d     = ctrl_wr ? wbs_dat_i[CtrlEnBit] : en_q;
  assign tx_ovf_d = (tx_ovf_q | (tx_wr & tx_full)) & ~clr_ovf;
  assign busy_d   = (state_q != StIdle) | ~tx_empty;

  rapcores_sync_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (tx_push),
    .data_i  (wbs_dat_i),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    cs_d       = cs_q;
    sck_d      = sck_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    sck_rise   = 1'b0;
    frame_end  = 1'b0;
    phase_done = (div_q == '0);
    div_d      = (state_q == StIdle || phase_done) ? DivMax : div_q - 1'b1;
    case (state_q)
      StIdle: begin
        if (en_q && !tx_empty) begin
          state_d = StSetup;
          tx_pop  = 1'b1;
          tx_sh_d = tx_head;
          cs_d    = 1'b0;
        end
      end
      StSetup: begin
        if (phase_done) begin
          state_d  = StShiftH;
          sck_d    = 1'b1;
          sck_rise = 1'b1;
        end
      end
      StShiftH: begin
        if (phase_done) begin
          state_d = StShiftL;
          sck_d   = 1'b0;
          tx_sh_d = {tx_sh_q[30:0], 1'b0};
        end
      end
      StShiftL: begin
        if (phase_done) begin
          if (bit_q == 5'd31) begin
            state_d = StHold;
            bit_d   = '0;
          end else begin
            state_d  = StShiftH;
            sck_d    = 1'b1;
            sck_rise = 1'b1;
            bit_d    = bit_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (phase_done) begin
          state_d   = StGap;
          cs_d      = 1'b1;
          frame_end = 1'b1;
        end
      end
      StGap: begin
        if (phase_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      tx_ovf_q <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      tx_sh_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      done_q   <= done_d;
      en_q     <= en_d;
      tx_ovf_q <= tx_ovf_d;
      busy_q   <= busy_d;
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      cs_q     <= cs_d;
      sck_q    <= sck_d;
      tx_sh_q  <= tx_sh_d;
    end
  end

`ifdef RAPCORES_SPI_RX_EN
  logic [31:0]     rx_sh_q, rx_head;
  logic [CntW-1:0] rx_count;
  logic            rx_pop, rx_full, rx_empty, rx_ovf_q;

  assign rx_pop = rd_cyc & (reg_sel == RegRxData) & ~rx_empty;

  // CIPO is captured on the same clock edge that raises SCK.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_sh_q  <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (sck_rise) rx_sh_q <= {rx_sh_q[30:0], spi_cipo_i};
      rx_ovf_q <= (rx_ovf_q | (frame_end & rx_full)) & ~clr_ovf;
    end
  end

  rapcores_sync_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (frame_end & ~rx_full),
    .data_i  (rx_sh_q),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign rx_cnt4 = 4'(rx_count);
  assign rx_word = rx_empty ? 32'h0 : rx_head;
  assign rx_ovf  = rx_ovf_q;
`else
  logic unused_rx;

  assign unused_rx = ^{spi_cipo_i, sck_rise, frame_end};
  assign rx_cnt4   = 4'h0;
  assign rx_word   = 32'h0;
  assign rx_ovf    = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegRxData: rdata = rx_word;
      RegStatus: begin
        rdata[StatTxCntLsb +: 4] = 4'(tx_count);
        rdata[StatRxCntLsb +: 4] = rx_cnt4;
        rdata[StatBusyBit]       = busy_q;
        rdata[StatTxOvfBit]      = tx_ovf_q;
        rdata[StatRxOvfBit]      = rx_ovf;
      end
      RegCtrl: rdata[CtrlEnBit] = en_q;
      default: rdata = '0;
    endcase
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = rd_cyc ? rdata : 32'h0;
  assign spi_sck_o  = sck_q;
  assign spi_cs_o   = cs_q;
  assign spi_copi_o = tx_sh_q[31];
  assign busy_o     = busy_q;

endmodule
